// File: rtl/sap_alu_seq_if.sv
// Controller-side handshake and operand bundle for the sequential SAP ALU.
// The tristate W bus is kept as a plain port on the ALU so that bus
// resolution stays at the top level.
interface sap_alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             enable;
    logic             busy;
    logic             done;
    logic [3:0]       flags;

    // Controller drives requests and observes status
    modport master (
        output start, op, a, b, enable,
        input  busy, done, flags
    );

    // ALU consumes requests and reports status
    modport slave (
        input  start, op, a, b, enable,
        output busy, done, flags
    );
endinterface

// File: rtl/sap_alu_seq.sv
// Registered SAP ALU: single-cycle arithmetic/logic/shift/compare plus an
// iterative shift-add multiply. Result and {V,N,Z,C} flags are held in
// registers; the result is driven onto the W bus when enabled.
module sap_alu_seq #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic              clk,
    input  logic              clr_n,
    sap_alu_seq_if.slave      bus,
    output wire  [WIDTH-1:0]  w_bus
);
    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_ADC = 4'h2, OP_SBC = 4'h3,
                           OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7,
                           OP_SHL = 4'h8, OP_SHR = 4'h9, OP_CMP = 4'hA, OP_MUL = 4'hB;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   result;
    logic [3:0]         flags;
    logic               done;

    logic [2*WIDTH-1:0] mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc_step;
    logic               mul_last;

    logic [WIDTH:0]     ext;
    logic [WIDTH-1:0]   alu_res;
    logic [3:0]         alu_flg;
    logic               we_res;
    logic               we_flg;
    logic               is_mul;
    logic               c_out;
    logic               v_out;

    logic [WIDTH:0]     cin_ext;
    assign cin_ext = {{WIDTH{1'b0}}, flags[0]};

    assign is_mul   = (bus.op == OP_MUL) && (MUL_EN != 0);
    assign acc_step = mul_b[0] ? acc + mul_a : acc;
    assign mul_last = (cnt == CW'(WIDTH - 1));

    assign bus.busy  = (state == S_MUL);
    assign bus.done  = done;
    assign bus.flags = flags;
    assign w_bus     = bus.enable ? result : {WIDTH{1'bz}};

    // Single-cycle ALU: candidate result/flags and which registers they update
    always_comb begin
        ext     = '0;
        alu_res = result;
        alu_flg = flags;
        we_res  = 1'b0;
        we_flg  = 1'b0;
        c_out   = 1'b0;
        v_out   = 1'b0;
        case (bus.op)
            OP_ADD, OP_ADC: begin
                ext   = {1'b0, bus.a} + {1'b0, bus.b} + ((bus.op == OP_ADC) ? cin_ext : '0);
                c_out = ext[WIDTH];
                v_out = (bus.a[MSB] == bus.b[MSB]) && (ext[MSB] != bus.a[MSB]);
                alu_res = ext[WIDTH-1:0];
                we_res  = 1'b1;
                we_flg  = 1'b1;
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                // Borrow shows up in the extra bit of the widened difference
                ext   = {1'b0, bus.a} - {1'b0, bus.b} - ((bus.op == OP_SUB) ? '0 : cin_ext);
                if (bus.op == OP_CMP) ext = {1'b0, bus.a} - {1'b0, bus.b};
                c_out = ext[WIDTH];
                v_out = (bus.a[MSB] != bus.b[MSB]) && (ext[MSB] != bus.a[MSB]);
                alu_res = ext[WIDTH-1:0];
                we_res  = (bus.op != OP_CMP);
                we_flg  = 1'b1;
            end
            OP_AND: begin alu_res = bus.a & bus.b; we_res = 1'b1; we_flg = 1'b1; end
            OP_OR:  begin alu_res = bus.a | bus.b; we_res = 1'b1; we_flg = 1'b1; end
            OP_XOR: begin alu_res = bus.a ^ bus.b; we_res = 1'b1; we_flg = 1'b1; end
            OP_NOT: begin alu_res = ~bus.a;        we_res = 1'b1; we_flg = 1'b1; end
            OP_SHL: begin
                alu_res = {bus.a[MSB-1:0], 1'b0};
                c_out   = bus.a[MSB];
                we_res  = 1'b1;
                we_flg  = 1'b1;
            end
            OP_SHR: begin
                alu_res = {1'b0, bus.a[MSB:1]};
                c_out   = bus.a[0];
                we_res  = 1'b1;
                we_flg  = 1'b1;
            end
            default: ;
        endcase
        if (we_flg) alu_flg = {v_out, ext[MSB] & 1'b0 | alu_res[MSB], (alu_res == '0), c_out};
    end

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: multiply is the only multi-cycle path
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.start && is_mul) state_nxt = S_MUL;
            S_MUL:  if (mul_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: register loads, shift-add iteration and done pulse
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            result <= '0;
            flags  <= '0;
            done   <= 1'b0;
            mul_a  <= '0;
            mul_b  <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE && bus.start) begin
                if (is_mul) begin
                    mul_a <= {{WIDTH{1'b0}}, bus.a};
                    mul_b <= bus.b;
                    acc   <= '0;
                    cnt   <= '0;
                end else begin
                    // Reserved opcodes still acknowledge with done
                    done <= 1'b1;
                    if (we_res) result <= alu_res;
                    if (we_flg) flags  <= alu_flg;
                end
            end else if (state == S_MUL) begin
                acc   <= acc_step;
                mul_a <= mul_a << 1;
                mul_b <= mul_b >> 1;
                cnt   <= cnt + 1'b1;
                if (mul_last) begin
                    result <= acc_step[WIDTH-1:0];
                    flags  <= {1'b0, acc_step[MSB], (acc_step[WIDTH-1:0] == '0),
                               (acc_step[2*WIDTH-1:WIDTH] != '0)};
                    done   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sap_alu_seq.sv
// Directed bench for sap_alu_seq (WIDTH=8, MUL_EN=1).
module tb_sap_alu_seq;
    logic       clk;
    logic       clr_n;
    wire  [7:0] w_bus;
    int         total;
    int         bad;

    sap_alu_seq_if #(.WIDTH(8)) bus_if ();

    sap_alu_seq #(.WIDTH(8), .MUL_EN(1)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus_if.slave),
        .w_bus (w_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it differs
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Issue a single-cycle op from a negedge; return at the negedge of the done cycle
    task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input string tag, input logic [7:0] exp_res, input logic [3:0] exp_flg);
        bus_if.start = 1'b1; bus_if.op = op; bus_if.a = a; bus_if.b = b;
        @(negedge clk);
        bus_if.start = 1'b0;
        chk({tag, ".done"},  {31'd0, bus_if.done}, 32'd1);
        chk({tag, ".res"},   {24'd0, dut.result},  {24'd0, exp_res});
        chk({tag, ".flags"}, {28'd0, bus_if.flags}, {28'd0, exp_flg});
    endtask

    // Launch a MUL, optionally poke start while busy; return at negedge of done cycle
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input bit poke,
                           output int busy_n, output int done_at, output int overlap);
        int cyc;
        busy_n = 0; done_at = 0; overlap = 0;
        bus_if.start = 1'b1; bus_if.op = 4'hB; bus_if.a = a; bus_if.b = b;
        @(negedge clk);
        bus_if.start = 1'b0;
        cyc = 1;
        while (cyc <= 20) begin
            if (bus_if.busy && bus_if.done) overlap++;
            if (bus_if.done) begin done_at = cyc; break; end
            if (bus_if.busy) busy_n++;
            if (poke && cyc == 3) begin
                bus_if.start = 1'b1; bus_if.op = 4'h0; bus_if.a = 8'h01; bus_if.b = 8'h01;
            end else begin
                bus_if.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus_if.start = 1'b0;
        if (done_at == 0) chk("mul.timeout", 32'd0, 32'd1);
    endtask

    int bn, da, ov;

    initial begin
        total = 0; bad = 0;
        bus_if.start = 1'b0; bus_if.op = 4'h0; bus_if.a = 8'h00; bus_if.b = 8'h00;
        bus_if.enable = 1'b0;
        clr_n = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst.res",   {24'd0, dut.result},  32'h00);
        chk("rst.flags", {28'd0, bus_if.flags}, 32'h0);
        chk("rst.busy",  {31'd0, bus_if.busy},  32'd0);
        chk("rst.done",  {31'd0, bus_if.done},  32'd0);
        bus_if.enable = 1'b1; #1;
        chk("rst.wbus", {24'd0, w_bus}, 32'h00);
        bus_if.enable = 1'b0;
        clr_n = 1'b1;
        @(negedge clk);

        do_op(4'h0, 8'h03, 8'h01, "add", 8'h04, 4'b0000);
        bus_if.enable = 1'b1; #1;
        chk("wbus.on", {24'd0, w_bus}, 32'h04);
        bus_if.enable = 1'b0; #1;
        chk("wbus.off", {31'd0, (w_bus === 8'h04)}, 32'd0);
        @(negedge clk);
        chk("done.pulse", {31'd0, bus_if.done}, 32'd0);

        do_op(4'h1, 8'h03, 8'h01, "sub1", 8'h02, 4'b0000);
        do_op(4'h1, 8'h01, 8'h03, "sub2", 8'hFE, 4'b0101);
        do_op(4'hA, 8'h05, 8'h05, "cmp",  8'hFE, 4'b0010);
        do_op(4'h0, 8'h7F, 8'h01, "addv", 8'h80, 4'b1100);
        do_op(4'h0, 8'hFF, 8'h01, "addc", 8'h00, 4'b0011);
        do_op(4'h2, 8'h00, 8'h00, "adc",  8'h01, 4'b0000);
        do_op(4'h1, 8'h01, 8'h03, "sub3", 8'hFE, 4'b0101);
        do_op(4'h3, 8'h05, 8'h02, "sbc",  8'h02, 4'b0000);
        do_op(4'h8, 8'h81, 8'h00, "shl",  8'h02, 4'b0001);
        do_op(4'h9, 8'h03, 8'h00, "shr",  8'h01, 4'b0001);
        do_op(4'h4, 8'hF0, 8'h3C, "and",  8'h30, 4'b0000);
        do_op(4'h5, 8'h00, 8'h00, "or",   8'h00, 4'b0010);
        do_op(4'h6, 8'hAA, 8'h55, "xor",  8'hFF, 4'b0100);
        do_op(4'h7, 8'hFF, 8'h00, "not",  8'h00, 4'b0010);
        do_op(4'hC, 8'h12, 8'h34, "rsv",  8'h00, 4'b0010);

        run_mul(8'h0F, 8'h11, 1'b1, bn, da, ov);
        chk("mul1.busy_n", bn, 32'd8);
        chk("mul1.done_at", da, 32'd9);
        chk("mul1.overlap", ov, 32'd0);
        chk("mul1.res",   {24'd0, dut.result},  32'hFF);
        chk("mul1.flags", {28'd0, bus_if.flags}, 32'b0100);
        @(negedge clk);
        chk("mul1.ignored", {31'd0, bus_if.done}, 32'd0);

        run_mul(8'h10, 8'h10, 1'b0, bn, da, ov);
        chk("mul2.done_at", da, 32'd9);
        chk("mul2.res",   {24'd0, dut.result},  32'h00);
        chk("mul2.flags", {28'd0, bus_if.flags}, 32'b0011);
        do_op(4'h0, 8'h02, 8'h03, "b2b", 8'h05, 4'b0000);

        bus_if.start = 1'b1; bus_if.op = 4'hB; bus_if.a = 8'h0F; bus_if.b = 8'h11;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort.busy_pre", {31'd0, bus_if.busy}, 32'd1);
        clr_n = 1'b0; #1;
        chk("abort.busy", {31'd0, bus_if.busy}, 32'd0);
        chk("abort.res",  {24'd0, dut.result},  32'h00);
        @(negedge clk);
        clr_n = 1'b1;
        bn = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus_if.done || bus_if.busy) bn++;
        end
        chk("abort.nodone", bn, 32'd0);
        do_op(4'h0, 8'h03, 8'h01, "post", 8'h04, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
